// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and memory-handshake controller for a five-stage pipeline.
// A three-state memory FSM (IDLE / WAIT / ABORT) drives the data-memory
// handshake and an access timeout. Every stall and flush output is
// combinational from the FSM state and the current inputs. The prioritised
// result is ABORT, then memory stall, then taken jump, then load-use.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_*    ID-stage source registers and their valid flags
//   ex_rd, ex_regwrite,        EX-stage destination, write enable and load flag
//   ex_memread, ex_jump        plus branch/jump-taken (resolved in EX)
//   mem_memread/mem_memwrite   MEM-stage access request flags
//   dmem_req / dmem_ack        data-memory request / acknowledge
//   *_stall                    hold enables for PC, IF/ID, ID/EX, EX/MEM
//   *_flush                    bubble-insert for IF/ID, ID/EX, EX/MEM, MEM/WB
//   mem_err                    one-cycle pulse when an access is aborted
//   cnt_clr, stall_cycles      clear and value of the PC-stall cycle counter
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic        ex_jump,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        mem_err,
    input  logic        cnt_clr,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_timer;
    logic [7:0]  w_timer_next;
    logic [31:0] r_stall_cycles;
    logic        w_mem_op;
    logic        w_mem_stall;
    logic        w_abort;
    logic        w_req;
    logic        w_load_use;

    assign w_mem_op = mem_memread | mem_memwrite;

    // Register x0 never carries a real dependency, so ex_rd==0 cannot hazard.
    assign w_load_use = ex_memread & ex_regwrite & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // Timer stays 0 outside WAIT, so entering WAIT always starts from zero.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = '0;
        w_mem_stall  = 1'b0;
        w_abort      = 1'b0;
        w_req        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_req        = 1'b1;
                    w_mem_stall  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (dmem_ack) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_mem_stall = 1'b1;
                    if (r_timer == TIMER_LAST) begin
                        w_state_next = S_ABORT;
                    end else begin
                        w_timer_next = r_timer + 8'd1;
                    end
                end
            end
            S_ABORT: begin
                w_abort      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A jump arriving under a memory stall is simply held in EX (id_ex_stall),
    // so it is acted on naturally in the release cycle without extra state.
    always_comb begin
        dmem_req     = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mem_err      = 1'b0;
        if (rstn) begin
            dmem_req = w_req;
            if (w_abort) begin
                mem_err      = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (w_mem_stall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_jump) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cycles <= '0;
        end else if (cnt_clr) begin
            r_stall_cycles <= '0;
        end else if (pc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    // Output vector order: dmem_req, pc/if_id/id_ex/ex_mem stall,
    // if_id/id_ex/ex_mem/mem_wb flush, mem_err.
    localparam logic [9:0] V_NONE    = 10'b0000000000;
    localparam logic [9:0] V_MSTALL  = 10'b1111100010;
    localparam logic [9:0] V_RELEASE = 10'b1000000000;
    localparam logic [9:0] V_REL_JMP = 10'b1000011000;
    localparam logic [9:0] V_ABORT   = 10'b0000011111;
    localparam logic [9:0] V_LU      = 10'b0110001000;
    localparam logic [9:0] V_JUMP    = 10'b0000011000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        ex_regwrite, ex_memread, ex_jump;
    logic        mem_memread, mem_memwrite, dmem_ack, cnt_clr;
    logic        dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model state: whether an access is outstanding, how many
    // unacknowledged wait cycles it has spent, whether an abort cycle is due.
    bit          m_busy;
    bit          m_abort;
    int          m_wait;
    logic [31:0] m_cnt;

    wire [9:0] act = {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err};

    pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_jump(ex_jump),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err), .cnt_clr(cnt_clr), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model_out();
        logic [9:0] o;
        bit mem_op, stall, lu;
        o = '0;
        if (!rstn) return o;
        if (m_abort) return V_ABORT;
        mem_op = mem_memread || mem_memwrite;
        lu = ex_memread && ex_regwrite && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        stall = m_busy ? !dmem_ack : mem_op;
        o[9] = m_busy || mem_op;
        if (stall) o[8:1] = 8'b1111_0001;
        else if (ex_jump) o[4:3] = 2'b11;
        else if (lu) begin
            o[8] = 1'b1;
            o[7] = 1'b1;
            o[3] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_abort = 1'b0;
        m_wait  = 0;
        m_cnt   = '0;
    endtask

    task automatic model_update();
        logic [9:0] o;
        o = model_out();
        if (!rstn) begin
            model_reset();
            return;
        end
        if (cnt_clr) m_cnt = '0;
        else if (o[8] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_abort) begin
            m_abort = 1'b0;
        end else if (!m_busy) begin
            if (mem_memread || mem_memwrite) begin
                m_busy = 1'b1;
                m_wait = 0;
            end
        end else if (dmem_ack) begin
            m_busy = 1'b0;
        end else if (m_wait + 1 == TO) begin
            m_busy  = 1'b0;
            m_abort = 1'b1;
        end else begin
            m_wait++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = '0; ex_regwrite = 0; ex_memread = 0; ex_jump = 0;
        mem_memread = 0; mem_memwrite = 0; dmem_ack = 0; cnt_clr = 0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    endtask

    task automatic rand_inputs();
        id_rs1       = 5'($urandom_range(0, 3));
        id_rs2       = 5'($urandom_range(0, 3));
        id_use_rs1   = ($urandom_range(0, 1) != 0);
        id_use_rs2   = ($urandom_range(0, 1) != 0);
        ex_rd        = 5'($urandom_range(0, 3));
        ex_regwrite  = ($urandom_range(0, 3) != 0);
        ex_memread   = ($urandom_range(0, 1) != 0);
        ex_jump      = ($urandom_range(0, 6) == 0);
        mem_memread  = ($urandom_range(0, 4) == 0);
        mem_memwrite = ($urandom_range(0, 5) == 0);
        dmem_ack     = ($urandom_range(0, 9) < 3);
        cnt_clr      = ($urandom_range(0, 40) == 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_inputs();
            mem_memread = 1; ex_jump = 1;
            #1;
            checks++;
            if ({act, stall_cycles} !== 42'd0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got %b cnt=%0d want all zero", i, act, stall_cycles);
            end
            tick();
        end
        @(negedge clk);
        set_idle();
        rstn = 1;
        #1;
        checks++;
        if (act !== V_NONE) begin
            failures++;
            $display("FAIL reset_release: got %b want %b", act, V_NONE);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic       mr_t [7];
        logic       rw_t [7];
        logic [4:0] rd_t [7];
        logic [4:0] r1_t [7];
        logic       u1_t [7];
        logic [4:0] r2_t [7];
        logic       u2_t [7];
        logic [9:0] ex_t [7];
        mr_t = '{1, 0, 1, 1, 1, 1, 0};
        rw_t = '{1, 0, 1, 1, 1, 0, 1};
        rd_t = '{5, 0, 0, 7, 7, 9, 9};
        r1_t = '{5, 5, 0, 3, 7, 9, 9};
        u1_t = '{1, 1, 1, 1, 0, 1, 1};
        r2_t = '{0, 0, 0, 7, 7, 0, 0};
        u2_t = '{0, 0, 1, 1, 0, 0, 0};
        ex_t = '{V_LU, V_NONE, V_NONE, V_LU, V_NONE, V_NONE, V_NONE};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_idle();
            ex_memread = mr_t[i]; ex_regwrite = rw_t[i]; ex_rd = rd_t[i];
            id_rs1 = r1_t[i]; id_use_rs1 = u1_t[i];
            id_rs2 = r2_t[i]; id_use_rs2 = u2_t[i];
            #1;
            checks++;
            if (act !== ex_t[i]) begin
                failures++;
                $display("FAIL load_use[%0d]: got %b want %b", i, act, ex_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_mem_access();
        logic [9:0] ex_t [4];
        ex_t = '{V_MSTALL, V_MSTALL, V_RELEASE, V_NONE};
        @(negedge clk);
        set_idle();
        cnt_clr = 1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            set_idle();
            mem_memread = (c == 1);
            dmem_ack    = (c == 3);
            #1;
            checks++;
            if (act !== ex_t[c-1]) begin
                failures++;
                $display("FAIL mem_access_c%0d: got %b want %b", c, act, ex_t[c-1]);
            end
            if (c == 4) begin
                checks++;
                if (stall_cycles !== 32'd2) begin
                    failures++;
                    $display("FAIL mem_access_stall_cycles: got %0d want 2", stall_cycles);
                end
            end
            tick();
        end
    endtask

    task automatic test_jump_under_stall();
        logic [9:0] ex_t [4];
        ex_t = '{V_MSTALL, V_MSTALL, V_REL_JMP, V_NONE};
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            set_idle();
            if (c <= 3) begin
                set_load_use();
                ex_jump = 1;
            end
            mem_memread = (c == 1);
            dmem_ack    = (c == 3);
            #1;
            checks++;
            if (act !== ex_t[c-1]) begin
                failures++;
                $display("FAIL jump_under_stall_c%0d: got %b want %b", c, act, ex_t[c-1]);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [9:0] ex_t [8];
        ex_t = '{V_MSTALL, V_MSTALL, V_MSTALL, V_MSTALL, V_MSTALL, V_ABORT, V_NONE, V_NONE};
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            set_idle();
            mem_memread = (c == 1) || (c == 6);
            dmem_ack    = (c >= 6);
            ex_jump     = (c == 6);
            #1;
            checks++;
            if (act !== ex_t[c-1]) begin
                failures++;
                $display("FAIL abort_c%0d: got %b want %b", c, act, ex_t[c-1]);
            end
            tick();
        end
    endtask

    task automatic test_jump_loaduse();
        logic [9:0] ex_t [3];
        ex_t = '{V_JUMP, V_JUMP, V_LU};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            if (i != 1) set_load_use();
            ex_jump = (i != 2);
            #1;
            checks++;
            if (act !== ex_t[i]) begin
                failures++;
                $display("FAIL jump_loaduse[%0d]: got %b want %b", i, act, ex_t[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        set_idle();
        mem_memread = 1;
        tick();
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (act !== V_MSTALL) begin
            failures++;
            $display("FAIL rst_wait_before: got %b want %b", act, V_MSTALL);
        end
        #1;
        rstn = 0;
        model_reset();
        #1;
        checks++;
        if ({act, stall_cycles} !== 42'd0) begin
            failures++;
            $display("FAIL rst_wait_during: got %b cnt=%0d want all zero", act, stall_cycles);
        end
        tick();
        // Ack high: a stale WAIT would release, IDLE must issue a new request.
        @(negedge clk);
        rstn = 1;
        mem_memread = 1;
        dmem_ack = 1;
        #1;
        checks++;
        if (act !== V_MSTALL) begin
            failures++;
            $display("FAIL rst_wait_idle_after: got %b want %b", act, V_MSTALL);
        end
        tick();
        @(negedge clk);
        mem_memread = 0;
        #1;
        checks++;
        if (act !== V_RELEASE) begin
            failures++;
            $display("FAIL rst_wait_ack: got %b want %b", act, V_RELEASE);
        end
        tick();
        @(negedge clk);
        set_idle();
        set_load_use();
        cnt_clr = 1;
        #1;
        checks++;
        if ({act, stall_cycles} !== {V_LU, 32'd1}) begin
            failures++;
            $display("FAIL cnt_clr_before: got %b cnt=%0d want %b cnt=1", act, stall_cycles, V_LU);
        end
        tick();
        @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL cnt_clr_after: got %0d want 0", stall_cycles);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_v;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            set_idle();
            mem_memwrite = 1;
            dmem_ack = 1;
            exp_v = (c % 2 == 0) ? V_MSTALL : V_RELEASE;
            #1;
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL back_to_back_c%0d: got %b want %b", c, act, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [9:0] exp_v;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rand_inputs();
            rstn = ($urandom_range(0, 99) != 0);
            if (!rstn) model_reset();
            #1;
            exp_v = model_out();
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL random_outputs c%0d: got %b want %b", c, act, exp_v);
            end
            checks++;
            if (stall_cycles !== m_cnt) begin
                failures++;
                $display("FAIL random_stall_cycles c%0d: got %0d want %0d", c, stall_cycles, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        rstn = 0;
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_mem_access();
        test_jump_under_stall();
        test_abort();
        test_jump_loaduse();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles spent in WAIT before a memory access is aborted (1..255).
REQ-002 SHALL have ports: clk in 1 clock; rstn in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: id_rs1, id_rs2 in 5 ID source regs; id_use_rs1, id_use_rs2 in 1 source-valid flags.
REQ-004 SHALL have ports: ex_rd in 5; ex_regwrite, ex_memread in 1; ex_jump in 1 branch/jump taken, resolved in EX.
REQ-005 SHALL have ports: mem_memread, mem_memwrite in 1 MEM-stage access flags.
REQ-006 SHALL have ports: dmem_req out 1; dmem_ack in 1 data-memory handshake.
REQ-007 SHALL have ports: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall out 1 register hold enables.
REQ-008 SHALL have ports: if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush out 1 synchronous bubble-insert to each register's is_flush.
REQ-009 SHALL have ports: mem_err out 1 one-cycle abort pulse; cnt_clr in 1; stall_cycles out 32 stall counter.

Function
REQ-010 SHALL implement memory FSM states IDLE, WAIT, ABORT; all other outputs combinational from state and inputs except stall_cycles and timer.
REQ-011 IDLE: mem_op = mem_memread|mem_memwrite; if mem_op -> dmem_req=1, mem stall asserted, next WAIT; else stay IDLE, dmem_req=0.
REQ-012 WAIT: dmem_req=1; dmem_ack=1 -> mem stall deasserted this cycle, next IDLE; dmem_ack=0 -> mem stall held, timer+1.
REQ-013 WAIT with dmem_ack=0 and timer==TIMEOUT-1 -> next ABORT; dmem_ack ignored in IDLE and ABORT.
REQ-014 ABORT (exactly 1 cycle): dmem_req=0, mem_err=1, mem_wb_flush=1, if_id_flush=id_ex_flush=ex_mem_flush=1, no stalls, next IDLE.
REQ-015 Timer 8-bit, cleared on entry to WAIT and in IDLE/ABORT.
REQ-016 Mem stall (IDLE with mem_op, or WAIT without ack): pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, all other flushes 0.
REQ-017 Load-use hazard = ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Load-use (no mem stall, no jump): pc_stall=if_id_stall=1, id_ex_flush=1, one bubble per hazard cycle.
REQ-019 ex_jump (no mem stall): if_id_flush=id_ex_flush=1, no stalls; load-use suppressed same cycle.
REQ-020 Priority: ABORT > mem stall > ex_jump > load-use; ex_jump under mem stall SHALL be deferred (EX held) and acted on when stall releases.
REQ-021 A register SHALL never see stall and flush asserted together.
REQ-022 stall_cycles SHALL increment when pc_stall=1, saturate at 0xFFFFFFFF; cnt_clr=1 clears to 0 synchronously, overriding increment.
REQ-023 Back-to-back memory ops: each SHALL take minimum 2 cycles in MEM (IDLE request + WAIT ack).

Reset
REQ-024 rstn=0 SHALL asynchronously force state IDLE, timer 0, stall_cycles 0; while in reset all outputs 0 regardless of inputs.
REQ-025 Reset in WAIT SHALL drop dmem_req immediately; no mem_err generated.
REQ-026 After rstn deasserts, first clk edge SHALL evaluate from IDLE.

Verification
REQ-027 Load: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 one cycle; with ex_rd=0 -> no stall.
REQ-028 mem_memread=1, dmem_ack high 3rd cycle -> dmem_req cycles 1-3, stalls cycles 1-2, released cycle 3, stall_cycles=2.
REQ-029 ex_jump=1 while mem stall active -> no if_id/id_ex flush until release cycle, then if_id_flush=id_ex_flush=1.
REQ-030 TIMEOUT=4, dmem_ack held 0 -> ABORT after 4 WAIT cycles, mem_err one cycle, all four flushes=1, back to IDLE.
REQ-031 ex_jump=1 and load-use same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-032 rstn pulsed low mid-WAIT -> dmem_req=0 immediately, stall_cycles=0, state IDLE; cnt_clr with pc_stall=1 -> stall_cycles=0.
